// File: rtl/sdf_pkg.sv
// Shared types and helpers for the SDF actor family: FSM state, mode codes,
// and a pointer-width helper that never returns zero.
package sdf_pkg;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   localparam int MODE_BCAST = 0;
   localparam int MODE_DIST  = 1;

   // A one-entry range still needs a 1-bit pointer.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sdf_out_port.sv
// One output lane of the fork actor: walks its own read pointer through the
// shared buffer and raises done once its share of the firing has been sent.
module sdf_out_port
   import sdf_pkg::*;
#(
   parameter int COUNT  = 4,
   parameter int STRIDE = 1,
   parameter int OFFSET = 0,
   parameter int IDX_W  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             emit,
   input  logic             fire_done,
   input  logic             ready,
   output logic             valid,
   output logic             done_next,
   output logic [IDX_W-1:0] idx
);

   localparam int RD_W = clog2_min1(COUNT);

   logic [RD_W-1:0] rd_q;
   logic            done_q;
   logic            xfer;
   logic            last;

   assign valid     = emit && !done_q && !reset;
   assign xfer      = valid && ready;
   assign last      = (rd_q == RD_W'(COUNT - 1));
   // Includes this cycle's final transfer so the firing can close without a bubble.
   assign done_next = done_q || (xfer && last);
   assign idx       = IDX_W'(OFFSET + int'(rd_q) * STRIDE);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of the order of statements.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q   <= '0;
         done_q <= 1'b0;
      end else if (fire_done) begin
         rd_q   <= '0;
         done_q <= 1'b0;
      end else if (xfer) begin
         if (last) begin
            rd_q   <= '0;
            done_q <= 1'b1;
         end else begin
            rd_q <= rd_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdf_actor_multirate_fork.sv
// SDF fork actor: gathers CONS tokens per firing, then broadcasts them to every
// output or deals them round-robin across the outputs.
module sdf_actor_multirate_fork
   import sdf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int N_OUT  = 2,
   parameter int CONS   = 4,
   parameter int MODE   = 0,
   parameter int CNT_W  = 16
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic [N_OUT-1:0]        out_valid,
   input  logic [N_OUT-1:0]        out_ready,
   output logic [CNT_W-1:0]        fire_count
);

   localparam int WR_W     = clog2_min1(CONS);
   localparam int LANE_CNT = (MODE == MODE_DIST) ? CONS / N_OUT : CONS;
   localparam int STRIDE   = (MODE == MODE_DIST) ? N_OUT : 1;

   if (N_OUT < 1 || N_OUT > 8) begin : g_bad_n_out
      $error("sdf_actor_multirate_fork: N_OUT must be in 1..8");
   end
   if (CONS < 1 || CONS > 64) begin : g_bad_cons
      $error("sdf_actor_multirate_fork: CONS must be in 1..64");
   end
   if (MODE == MODE_DIST && (CONS % N_OUT) != 0) begin : g_bad_dist
      $error("sdf_actor_multirate_fork: distribute mode needs CONS divisible by N_OUT");
   end

   state_t            state_q;
   logic [WR_W-1:0]   wr_cnt_q;
   logic [DATA_W-1:0] buf_mem [CONS];
   logic              emit;
   logic              accept;
   logic              fire_done;
   logic [N_OUT-1:0]  done_next;
   logic [WR_W-1:0]   lane_idx [N_OUT];

   assign emit      = (state_q == ST_EMIT);
   assign in_ready  = (state_q == ST_FILL) && !reset_reset;
   assign accept    = in_valid && in_ready;
   assign fire_done = emit && (&done_next);

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q    <= ST_FILL;
         wr_cnt_q   <= '0;
         fire_count <= '0;
      end else begin
         case (state_q)
            ST_FILL: begin
               if (accept) begin
                  if (wr_cnt_q == WR_W'(CONS - 1)) begin
                     state_q  <= ST_EMIT;
                     wr_cnt_q <= '0;
                  end else begin
                     wr_cnt_q <= wr_cnt_q + 1'b1;
                  end
               end
            end
            ST_EMIT: begin
               if (fire_done) begin
                  state_q    <= ST_FILL;
                  fire_count <= fire_count + 1'b1;
               end
            end
            default: state_q <= ST_FILL;
         endcase
      end
   end

   // NOTE: the token buffer has no reset; every entry is rewritten during FILL
   // before EMIT can read it, so clearing it would only cost logic.
   always_ff @(posedge clk_clk) begin
      if (accept) begin
         buf_mem[wr_cnt_q] <= in_data;
      end
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_port
      sdf_out_port #(
         .COUNT  (LANE_CNT),
         .STRIDE (STRIDE),
         .OFFSET ((MODE == MODE_DIST) ? k : 0),
         .IDX_W  (WR_W)
      ) u_port (
         .clk       (clk_clk),
         .reset     (reset_reset),
         .emit      (emit),
         .fire_done (fire_done),
         .ready     (out_ready[k]),
         .valid     (out_valid[k]),
         .done_next (done_next[k]),
         .idx       (lane_idx[k])
      );
   end

   // NOTE: out_data gets a full default before the loop so no bit can hold its
   // old value, which would otherwise infer a latch.
   always_comb begin
      out_data = '0;
      for (int k = 0; k < N_OUT; k++) begin
         if (out_valid[k]) begin
            out_data[k*DATA_W +: DATA_W] = buf_mem[lane_idx[k]];
         end
      end
   end

endmodule

// File: tb/tb_sdf_actor_multirate_fork.sv
// Scoreboard bench: a broadcast instance (CNT_W=2) and a distribute instance
// share clock and reset; a token-level model predicts every lane's stream.
module tb_sdf_actor_multirate_fork;

   localparam int DW = 32;
   localparam int NO = 2;
   localparam int CN = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [DW-1:0]    in_data   [2];
   logic             in_valid  [2];
   logic             in_ready  [2];
   logic [NO*DW-1:0] out_data  [2];
   logic [NO-1:0]    out_valid [2];
   logic [NO-1:0]    out_ready [2];
   logic [1:0]       fc_a;
   logic [15:0]      fc_b;
   logic [15:0]      fc [2];

   assign fc[0] = {14'd0, fc_a};
   assign fc[1] = fc_b;

   sdf_actor_multirate_fork #(.DATA_W(DW), .N_OUT(NO), .CONS(CN), .MODE(0), .CNT_W(2)) u_bc (
      .clk_clk(clk), .reset_reset(reset),
      .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .fire_count(fc_a)
   );

   sdf_actor_multirate_fork #(.DATA_W(DW), .N_OUT(NO), .CONS(CN), .MODE(1), .CNT_W(16)) u_ds (
      .clk_clk(clk), .reset_reset(reset),
      .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .fire_count(fc_b)
   );

   int n_checks = 0;
   int n_err    = 0;

   logic [DW-1:0] exp_q [4][$];     // lane d*NO+k
   logic [DW-1:0] pend  [2][$];     // tokens of the firing being filled
   int            fires [2] = '{0, 0};
   int            cyc = 0;
   int            hold_end [2] = '{0, 0};
   bit            rdy_rand [2] = '{1'b0, 1'b0};
   bit            prev_stall [4] = '{4{1'b0}};
   logic [DW-1:0] prev_data  [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] mask(input int d);
      return (d == 0) ? 16'h0003 : 16'hFFFF;
   endfunction

   // Instance 0 broadcasts every token to both lanes, instance 1 deals token i to lane i%NO.
   task automatic model_accept(input int d, input logic [DW-1:0] v);
      if (pend[d].size() == 0) check("fire_count_at_fill", fc[d], fires[d] & mask(d));
      pend[d].push_back(v);
      if (pend[d].size() == CN) begin
         for (int i = 0; i < CN; i++) begin
            if (d == 0) begin
               for (int k = 0; k < NO; k++) exp_q[k].push_back(pend[d][i]);
            end else begin
               exp_q[NO + (i % NO)].push_back(pend[d][i]);
            end
         end
         pend[d].delete();
         fires[d]++;
      end
   endtask

   function automatic bit lanes_empty(input int d);
      for (int k = 0; k < NO; k++) if (exp_q[d*NO + k].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic send(input int d, input logic [DW-1:0] v, input bit gap);
      int  n = 0;
      bit  sent = 1'b0;
      if (gap) @(negedge clk);
      while (!sent) begin
         @(negedge clk);
         in_valid[d] = 1'b1;
         in_data[d]  = v;
         #1;
         if (in_ready[d]) begin
            check("fill_no_valid", out_valid[d], '0);
            check("fill_lanes_drained", lanes_empty(d), 1);
            model_accept(d, v);
            sent = 1'b1;
         end else if (++n > 300) begin
            check("in_ready_timeout", in_ready[d], 1);
            sent = 1'b1;
         end
      end
      @(posedge clk);
      #1 in_valid[d] = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int n = 0;
      @(negedge clk); #1;
      while (!in_ready[d] && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      check("drain_in_ready", in_ready[d], 1);
      check("drain_fire_count", fc[d], fires[d] & mask(d));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0;
         pend[d].delete();
         fires[d] = 0;
      end
      for (int i = 0; i < 4; i++) exp_q[i].delete();
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_in_ready", in_ready[d], 0);
         check("rst_out_valid", out_valid[d], '0);
         check("rst_out_data", out_data[d], '0);
         check("rst_fire_count", fc[d], 0);
      end
      reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check("post_rst_in_ready", in_ready[d], 1);
         check("post_rst_out_valid", out_valid[d], '0);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         automatic logic [NO-1:0] r = rdy_rand[d] ? NO'($urandom) : '1;
         if (cyc <= hold_end[d]) r[1] = 1'b0;
         out_ready[d] = r;
      end
   end

   // Monitor: pops the scoreboard on every handshake and polices stall stability.
   always @(negedge clk) begin
      #2;
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < NO; k++) begin
            automatic int            i   = d*NO + k;
            automatic logic [DW-1:0] dat = out_data[d][k*DW +: DW];
            automatic logic          v   = out_valid[d][k];
            automatic logic          r   = out_ready[d][k];
            if (reset) begin
               prev_stall[i] = 1'b0;
            end else begin
               if (prev_stall[i]) begin
                  check("stall_valid_held", v, 1);
                  check("stall_data_held", dat, prev_data[i]);
               end
               if (v) begin
                  if (exp_q[i].size() == 0) check("valid_without_token", v, 0);
                  else if (r) check("lane_data", dat, exp_q[i].pop_front());
               end
               prev_stall[i] = v && !r;
               prev_data[i]  = dat;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0;
         in_data[d]  = '0;
      end
      do_reset();

      // Broadcast: 1..4 on both lanes, valid right after the 4th accept.
      for (int v = 1; v <= 4; v++) send(0, DW'(v), 1'b0);
      @(negedge clk); #1;
      check("bc_latency_valid", out_valid[0], 2'b11);
      check("bc_emit_in_ready", in_ready[0], 0);
      repeat (3) begin
         @(negedge clk); #1;
         check("bc_emit_in_ready", in_ready[0], 0);
      end
      @(negedge clk); #1;
      check("bc_in_ready_back", in_ready[0], 1);
      check("bc_fire_count", fc[0], 1);

      // Distribute: lane0 gets 10,12 and lane1 gets 11,13.
      for (int v = 10; v <= 13; v++) send(1, DW'(v), 1'b0);
      @(negedge clk); #1;
      check("ds_latency_valid", out_valid[1], 2'b11);
      @(negedge clk); #1;
      check("ds_emit_in_ready", in_ready[1], 0);
      @(negedge clk); #1;
      check("ds_in_ready_back", in_ready[1], 1);
      check("ds_fire_count", fc[1], 1);

      // Backpressure: lane1 not ready for 5 cycles, lane0 runs ahead.
      for (int v = 31; v <= 34; v++) send(0, DW'(v), 1'b0);
      hold_end[0] = cyc + 5;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check("bp_in_ready", in_ready[0], 0);
         check("bp_lane0_valid", out_valid[0][0], (i < 4));
         check("bp_lane1_valid", out_valid[0][1], 1);
         check("bp_lane1_data", out_data[0][DW +: DW], 31);
      end
      repeat (4) begin
         @(negedge clk); #1;
         check("bp_drain_in_ready", in_ready[0], 0);
      end
      @(negedge clk); #1;
      check("bp_in_ready_back", in_ready[0], 1);
      check("bp_fire_count", fc[0], 2);

      // Gapped input on the distribute instance.
      for (int v = 40; v <= 43; v++) send(1, DW'(v), 1'b1);
      wait_idle(1);

      // Reset in the middle of EMIT after two transfers, then a fresh firing.
      for (int v = 50; v <= 53; v++) send(0, DW'(v), 1'b0);
      @(negedge clk);
      @(negedge clk);
      do_reset();
      for (int v = 60; v <= 63; v++) send(0, DW'(v), 1'b0);
      wait_idle(0);
      check("wrap_fc_1", fc[0], 1);

      // Four more firings take the 2-bit counter through 2,3,0,1.
      rdy_rand[0] = 1'b1;
      for (int f = 0; f < 4; f++) begin
         for (int t = 0; t < CN; t++) send(0, $urandom, 1'b0);
         wait_idle(0);
      end
      check("wrap_fc_final", fc[0], 1);

      // Random traffic on both instances concurrently.
      rdy_rand[1] = 1'b1;
      fork
         begin
            for (int f = 0; f < 20; f++)
               for (int t = 0; t < CN; t++) send(0, $urandom, 1'($urandom_range(0, 1)));
         end
         begin
            for (int f = 0; f < 20; f++)
               for (int t = 0; t < CN; t++) send(1, $urandom, 1'($urandom_range(0, 1)));
         end
      join
      wait_idle(0);
      wait_idle(1);
      for (int i = 0; i < 4; i++) check("scoreboard_empty", exp_q[i].size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/sdf_actor_multirate_fork.md
# sdf_actor_multirate_fork

Parametrised synchronous-dataflow (SDF) actor with one 32-bit-class input stream and N_OUT output streams. Each firing consumes a fixed CONS tokens into a local buffer. It then either broadcasts all CONS tokens to every output or distributes them round-robin across the outputs. The block replaces the fixed one-in/two-out actor in the SDF HLS component system and sits between Avalon-ST producer and consumer actors inside the Platform Designer system.

## Interface
Parameters:
- DATA_W, 32, token width in bits
- N_OUT, 2, number of output streams (1..8)
- CONS, 4, input tokens consumed per firing (1..64)
- MODE, 0, 0 = broadcast (each output emits all CONS tokens), 1 = distribute (token i goes to output i mod N_OUT); MODE 1 requires CONS % N_OUT == 0, checked by elaboration assertion
- CNT_W, 16, width of firing counter

Ports (one clock; reset is synchronous and active-high):
- clk_clk  in  1  single clock, all logic on rising edge
- reset_reset  in  1  synchronous active-high reset
- in_data  in  DATA_W  input token (Avalon-ST sink)
- in_valid  in  1  input token valid
- in_ready  out  1  block accepts token this cycle
- out_data  out  N_OUT*DATA_W  output k on bits [k*DATA_W +: DATA_W]
- out_valid  out  N_OUT  per-output valid
- out_ready  in  N_OUT  per-output ready
- fire_count  out  CNT_W  number of completed firings, wraps modulo 2^CNT_W

## Operation
- States: FILL and EMIT. Reset enters FILL with wr_cnt=0, all per-output read pointers 0, all done flags 0, fire_count=0.
- FILL:
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready, buf[wr_cnt] <= in_data and wr_cnt increments.
  - Accepting the token at wr_cnt==CONS-1 moves the block to EMIT and clears wr_cnt.
- EMIT:
  - in_ready=0.
  - Each output k runs independently from its own pointer rd[k] and flag done[k].
  - Broadcast: output k presents buf[rd[k]], and rd[k] runs 0..CONS-1.
  - Distribute: output k presents buf[k + rd[k]*N_OUT], and rd[k] runs 0..CONS/N_OUT-1.
  - out_valid[k] = !done[k].
  - On out_valid[k]&&out_ready[k], rd[k] advances. Transferring the last token sets done[k] and clears rd[k].
  - When every done flag is set (including flags set in the current cycle), the block returns to FILL, clears the done flags and increments fire_count.
- Outputs never stall each other within a firing. A slow output only delays the next FILL.
- No token reordering within an output stream. Tokens are never dropped or duplicated beyond the broadcast rule.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 from the first cycle after reset release; out_valid=0; out_data=0; fire_count=0.
- Latency: out_valid rises on the cycle after the CONS-th input token is accepted.
- in_ready rises on the cycle after the last output transfer of a firing. There is no same-cycle FILL/EMIT overlap.
- Minimum firing period is CONS + (CONS or CONS/N_OUT) cycles with all ready inputs held high.
- Avalon-ST rules:
  - Once asserted, out_valid[k] stays high until accepted.
  - out_data lane k stays stable while out_valid[k]&&!out_ready[k].
  - out_data is don't-care when invalid.
- in_valid while in_ready=0 is ignored. The producer holds the token.
- Reset asserted mid-FILL or mid-EMIT discards buffer contents and all partial pointers. On the next cycle the block is back in its reset state.
- fire_count wraps from 2^CNT_W-1 to 0 silently.

## Structure
- Shared package sdf_pkg holds:
  - the state enum (ST_FILL, ST_EMIT)
  - the mode constants (MODE_BCAST=0, MODE_DIST=1)
  - helper function clog2_min1 for pointer widths
- Sub-module sdf_out_port, instantiated N_OUT times:
  - holds rd pointer, done flag and valid/ready logic
  - takes the buffer lane index count (CONS or CONS/N_OUT), the stride and the start offset as parameters
- Buffer is a plain register array in the top module (CONS ≤ 64, no RAM inference required).

## Test plan
- Broadcast, N_OUT=2, CONS=4, all ready high; input 1,2,3,4 -> both outputs emit 1,2,3,4 starting the cycle after token 4 is accepted; fire_count=1; in_ready returns 1 after 4 output cycles.
- Distribute, N_OUT=2, CONS=4; input 10,11,12,13 -> out0 emits 10,12 and out1 emits 11,13; fire_count=1 after 2 output cycles.
- Backpressure: out_ready[1] held low 5 cycles -> out0 completes all tokens; out1 holds data 1 stable with valid high; in_ready stays 0 until out1 finishes.
- Input gaps: in_valid toggled 1,0,1,0… -> exactly CONS tokens captured in order; no transition to EMIT before the 4th accept.
- Reset mid-EMIT after 2 of 4 tokens on out0 -> next cycle out_valid=0, in_ready=1, fire_count=0; a fresh 4-token firing emits only the new values.
- CNT_W=2, 5 firings -> fire_count sequence 1,2,3,0,1.
